seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential 8-bit by 4-bit unsigned restoring divider.
// One quotient bit per clock, MSB first; results and status flags are registered.
module seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] dvsr_q, dvsr_d;
  logic [3:0] prem_q, prem_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       dbz_q, dbz_d;

  logic [4:0] trial_s;
  logic [3:0] diff_s;
  logic       ge_s;
  logic [3:0] next_rem_s;
  logic [7:0] next_shift_s;

  // One restoring step; the dividend register doubles as the quotient
  // accumulator, so after eight shifts it holds the full quotient.
  always_comb begin
    trial_s      = {prem_q, shift_q[7]};
    ge_s         = (trial_s >= {1'b0, dvsr_q});
    diff_s       = trial_s[3:0] - dvsr_q;
    next_shift_s = {shift_q[6:0], ge_s};
    if (ge_s) begin
      next_rem_s = diff_s;
    end else begin
      next_rem_s = trial_s[3:0];
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dvsr_d  = dvsr_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = dividend;
          dvsr_d  = divisor;
          prem_d  = 4'd0;
          cnt_d   = 3'd0;
          if (divisor == 4'd0) begin
            state_d = DONE;
            quot_d  = 8'hFF;
            rem_d   = 4'hF;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        shift_d = next_shift_s;
        prem_d  = next_rem_s;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          quot_d  = next_shift_s;
          rem_d   = next_rem_s;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= 8'd0;
      dvsr_q  <= 4'd0;
      prem_q  <= 4'd0;
      cnt_q   <= 3'd0;
      quot_q  <= 8'd0;
      rem_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
